// File: rtl/uart_rx_par_deser_pkg.sv
// Shared UART receive definitions: frame states, parity encodings and the
// expected-parity helper used by both the TX generator and the RX checker.
package uart_rx_par_deser_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Takes the XOR-reduction of the data word so the helper works for any width.
  function automatic logic exp_parity(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_par_chk.sv
// Expected-parity compare for a received word and the sticky parity error flag.
module uart_rx_par_chk
  import uart_rx_par_deser_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  chk_en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  output logic                  par_err
);

  logic expected_bit;
  logic par_err_reg;

  assign expected_bit = exp_parity(^data, par_typ);
  assign par_err      = par_err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_err_reg <= 1'b0;
    end else if (clear) begin
      par_err_reg <= 1'b0;
    end else if (chk_en) begin
      par_err_reg <= (sampled_bit != expected_bit);
    end
  end

endmodule

// File: rtl/uart_rx_par_deser.sv
// UART RX deserializer: shifts in LSB-first data bits, checks optional parity
// and the stop bit, and presents the word with a one-cycle valid pulse.
module uart_rx_par_deser
  import uart_rx_par_deser_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  bit_strb,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  rx_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next, shift_in;
  logic [DATA_WIDTH-1:0] p_data_reg;
  logic                  par_en_reg, par_typ_reg;
  logic                  data_valid_reg, stp_err_reg;
  logic                  start_frame, chk_en, stop_take;

  // New bit enters at the MSB so the first received bit ends up in bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
      assign shift_in[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shift_in[DATA_WIDTH-1] = sampled_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    start_frame = 1'b0;
    chk_en      = 1'b0;
    stop_take   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_start) begin
          start_frame = 1'b1;
          cnt_next    = '0;
          shift_next  = '0;
          state_next  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_strb) begin
          shift_next = shift_in;
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_BIT) begin
            state_next = par_en_reg ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_strb) begin
          chk_en     = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_strb) begin
          stop_take  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg        <= '0;
      shift_reg      <= '0;
      p_data_reg     <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= PAR_EVEN;
      data_valid_reg <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      data_valid_reg <= 1'b0;
      if (start_frame) begin
        par_en_reg  <= PAR_EN;
        par_typ_reg <= PAR_TYP;
        stp_err_reg <= 1'b0;
      end
      if (stop_take) begin
        stp_err_reg <= ~sampled_bit;
        if (!par_err && sampled_bit) begin
          p_data_reg     <= shift_reg;
          data_valid_reg <= 1'b1;
        end
      end
    end
  end

  uart_rx_par_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_par_chk (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_frame),
    .chk_en      (chk_en),
    .data        (shift_reg),
    .par_typ     (par_typ_reg),
    .sampled_bit (sampled_bit),
    .par_err     (par_err)
  );

  assign P_DATA     = p_data_reg;
  assign Data_Valid = data_valid_reg;
  assign stp_err    = stp_err_reg;
  assign Busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_par_deser.sv
// Directed bench for uart_rx_par_deser with a scoreboard of expected words.
module tb_uart_rx_par_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         frame_start = 1'b0;
  logic         bit_strb = 1'b0;
  logic         sampled_bit = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         par_err;
  logic         stp_err;
  logic         Busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  uart_rx_par_deser #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bit_strb    (bit_strb),
    .sampled_bit (sampled_bit),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .Busy        (Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (Data_Valid === 1'b1) begin
      check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("p_data", 32'(P_DATA), 32'(e));
        check("busy_at_valid", 32'(Busy), 32'd0);
        $display("frame received data=%02h", P_DATA);
      end
    end
  endtask

  task automatic send_bit(input logic b);
    bit_strb = 1'b1;
    sampled_bit = b;
    step();
    bit_strb = 1'b0;
    sampled_bit = 1'b0;
    step();
  endtask

  task automatic send_bits(input logic [W-1:0] d, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(d[i]);
  endtask

  task automatic start(input logic en, input logic typ);
    PAR_EN = en;
    PAR_TYP = typ;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("busy_after_start", 32'(Busy), 32'd1);
  endtask

  // Complete frame; the scoreboard entry is pushed just before the stop bit.
  task automatic send_frame(input logic [W-1:0] d, input logic en, input logic typ,
                            input logic pbit, input logic stop, input logic good);
    start(en, typ);
    send_bits(d, 0, W - 1);
    if (en) send_bit(pbit);
    if (good) exp_q.push_back(d);
    send_bit(stop);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    check("rst_p_data", 32'(P_DATA), 32'd0);
    check("rst_valid", 32'(Data_Valid), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_stp_err", 32'(stp_err), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    reset = 1'b1;
    step();

    // Even parity, 0xA5, parity 0
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("even_par_err", 32'(par_err), 32'd0);
    check("even_stp_err", 32'(stp_err), 32'd0);
    check("even_pdata", 32'(P_DATA), 32'hA5);

    // Odd parity, good then bad parity bit
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("odd_par_err", 32'(par_err), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("odd_bad_par_err", 32'(par_err), 32'd1);
    check("odd_bad_pdata_held", 32'(P_DATA), 32'hA5);
    check("odd_bad_stp_err", 32'(stp_err), 32'd0);
    $display("frame data=a5 rejected on parity");

    // No parity, bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stop_stp_err", 32'(stp_err), 32'd1);
    check("stop_par_err_cleared", 32'(par_err), 32'd0);
    check("stop_busy", 32'(Busy), 32'd0);
    check("stop_pdata_held", 32'(P_DATA), 32'hA5);
    $display("frame data=3c rejected on stop bit");

    // Config latched at frame_start; PAR_TYP change mid-frame ignored
    start(1'b1, 1'b0);
    check("start_clears_stp_err", 32'(stp_err), 32'd0);
    send_bits(8'h01, 0, 2);
    PAR_TYP = 1'b1;
    send_bits(8'h01, 3, W - 1);
    send_bit(1'b1);
    exp_q.push_back(8'h01);
    send_bit(1'b1);
    check("latched_cfg_drained", 32'(exp_q.size()), 32'd0);
    check("latched_cfg_par_err", 32'(par_err), 32'd0);
    PAR_TYP = 1'b0;

    // frame_start mid-frame ignored
    start(1'b0, 1'b0);
    send_bits(8'hF0, 0, 3);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("busy_mid_restart", 32'(Busy), 32'd1);
    send_bits(8'hF0, 4, W - 1);
    exp_q.push_back(8'hF0);
    send_bit(1'b1);
    check("restart_ignored_drained", 32'(exp_q.size()), 32'd0);

    // Strobes while idle do nothing
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0);
      check("idle_strb_busy", 32'(Busy), 32'd0);
    end
    check("idle_strb_pdata", 32'(P_DATA), 32'hF0);
    check("idle_strb_stp_err", 32'(stp_err), 32'd0);

    // Reset mid-frame takes effect without a clock edge
    start(1'b1, 1'b0);
    send_bits(8'h5A, 0, 4);
    reset = 1'b0;
    #1;
    check("midrst_p_data", 32'(P_DATA), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_valid", 32'(Data_Valid), 32'd0);
    check("midrst_errs", 32'({par_err, stp_err}), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_rst_pdata", 32'(P_DATA), 32'h5A);

    repeat (3) step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_par_deser.md
Name: uart_rx_par_deser

Overview:
- Receive-side counterpart of the TX parity generator.
- Takes per-bit samples from the UART RX data sampler and shifts in DATA_WIDTH data bits, LSB first.
- Checks the optional parity bit against PAR_TYP, then the stop bit, and presents the parallel byte with a one-cycle valid pulse.
- Sits between the RX edge/bit counter + sampler and the RX sync/register-file interface.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  system clock (UART RX clock domain).
- reset  input  1  asynchronous, active-low reset.
- frame_start  input  1  one-cycle pulse from upstream: start bit validated.
- bit_strb  input  1  one-cycle pulse: sampled_bit holds the next frame bit after start.
- sampled_bit  input  1  majority-voted bit value.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity (same encoding as TX).
- P_DATA  output  DATA_WIDTH  last good received word.
- Data_Valid  output  1  one-cycle pulse: P_DATA updated with a good frame.
- par_err  output  1  parity mismatch on current/last frame.
- stp_err  output  1  stop bit sampled as 0 on current/last frame.
- Busy  output  1  high while a frame is being assembled.

Behaviour:
- Reset (async, reset=0) drives:
  - P_DATA=0, Data_Valid=0, par_err=0, stp_err=0, Busy=0.
  - State=IDLE, shift register=0, bit counter=0.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - On frame_start: latch PAR_EN/PAR_TYP into config regs, clear par_err and stp_err, clear bit counter and shift reg, go to DATA. Busy=1 from the next cycle.
  - bit_strb in IDLE is ignored.
- DATA:
  - Each bit_strb shifts sampled_bit in at the MSB end (shift right), so after DATA_WIDTH strobes bit 0 = first received bit.
  - Counter increments per strobe.
  - After the DATA_WIDTH-th strobe, go to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY:
  - On bit_strb compute expected = (^shift) when latched PAR_TYP=0, ~(^shift) when PAR_TYP=1.
  - par_err <= (sampled_bit != expected). Go to STOP.
- STOP:
  - On bit_strb, stp_err <= ~sampled_bit. Go to IDLE.
  - If no error (par_err=0 and sampled_bit=1): load P_DATA with the shift register and pulse Data_Valid for exactly one cycle.
  - Update and pulse happen in the cycle after the strobe.
  - On error, P_DATA is held and there is no pulse.
- Busy deasserts in the same cycle Data_Valid asserts.
- Error flags are sticky until the next accepted frame_start.
- frame_start while not IDLE: ignored; the frame in progress continues.
- frame_start and bit_strb in the same cycle in IDLE: frame_start is taken, the strobe is dropped.
- PAR_EN/PAR_TYP changes mid-frame have no effect; the latched values are used.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The partial frame is discarded.
- No back-pressure: the consumer must accept the Data_Valid pulse.

Decomposition:
- Shared uart_pkg (or header defines):
  - state encoding constants for IDLE/DATA/PARITY/STOP;
  - PAR_EVEN=0, PAR_ODD=1;
  - default DATA_WIDTH.
- Parity function reused from the TX side as a shared function.
- One natural sub-module: uart_rx_par_chk, the combinational expected-parity plus the registered par_err. The FSM, counter and shift register stay in the top.

Test Plan:
- Even parity, frame_start then bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), parity bit 0, stop 1 -> one-cycle Data_Valid, P_DATA=0xA5, par_err=0, stp_err=0.
- Odd parity, 0xA5 with parity bit 1, stop 1 -> P_DATA=0xA5, Data_Valid pulses. Repeat with parity bit 0 -> par_err=1, no Data_Valid, P_DATA keeps 0xA5.
- PAR_EN=0, 0x3C then stop 0 -> stp_err=1, no Data_Valid, Busy low after the stop strobe. Next frame_start -> stp_err clears.
- PAR_EN=1, PAR_TYP=0 latched at frame_start, PAR_TYP toggled to 1 after the 3rd data bit, 0x01 with parity bit 1 -> accepted (even check used), Data_Valid pulses.
- Extra frame_start during DATA after 4 bits of 0xF0 -> ignored; completing the frame yields P_DATA=0xF0. bit_strb pulses while IDLE -> no state change.
- reset asserted after the 5th data bit -> all outputs 0 immediately. Then a full 0x5A even frame -> P_DATA=0x5A, Data_Valid pulse.
